// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and read-port state type for the register file.
//   REGFILE_WIDTH - data width of each register
//   REGFILE_NREGS - number of registers
//   REGFILE_AW    - register index width (log2 of REGFILE_NREGS)
//   rd_state_e    - read-port FSM states (2-bit encoding)
package regfile_pkg;

    localparam int unsigned REGFILE_WIDTH = 16;
    localparam int unsigned REGFILE_NREGS = 8;
    localparam int unsigned REGFILE_AW    = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ_A = 2'd1,
        READ_B = 2'd2,
        DONE   = 2'd3
    } rd_state_e;

endpackage

// File: rtl/reg_read_mux.sv
// reg_read_mux: combinational NREGS:1 selection of one WIDTH-bit register
// from the flattened register file.
//   regs_i [NREGS*WIDTH] - flattened registers, reg0 in the low slice
//   idx_i  [AW]          - register index
//   data_o [WIDTH]       - selected register contents
module reg_read_mux
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = REGFILE_WIDTH,
    parameter int unsigned NREGS = REGFILE_NREGS,
    parameter int unsigned AW    = REGFILE_AW
) (
    input  logic [NREGS*WIDTH-1:0] regs_i,
    input  logic [AW-1:0]          idx_i,
    output logic [WIDTH-1:0]       data_o
);

    always_comb begin
        data_o = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (idx_i == AW'(i)) begin
                data_o = regs_i[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/regfile_read_port.sv
// regfile_read_port: read side of the register file. Fetches operand A then
// operand B through one shared read mux over two cycles.
//   clk, rst_n          - clock, asynchronous active-low reset
//   regs_in             - flattened register file contents (reg0 lowest)
//   rd_req, rd_ready    - request/ready handshake; readnum_a/b captured on accept
//   a_out, b_out        - registered operands
//   op_valid, op_ack    - valid/ack handshake towards the operand consumer
//   write, writenum,
//   wr_data             - register-file write port, used only for forwarding
// Optional feature: define REGFILE_READ_BYPASS_EN to forward a same-cycle
// register-file write into the operand being read.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = REGFILE_WIDTH,
    parameter int unsigned NREGS = REGFILE_NREGS,
    parameter int unsigned AW    = REGFILE_AW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREGS*WIDTH-1:0] regs_in,
    input  logic                   rd_req,
    input  logic [AW-1:0]          readnum_a,
    input  logic [AW-1:0]          readnum_b,
    output logic                   rd_ready,
    output logic [WIDTH-1:0]       a_out,
    output logic [WIDTH-1:0]       b_out,
    output logic                   op_valid,
    input  logic                   op_ack,
    input  logic                   write,
    input  logic [AW-1:0]          writenum,
    input  logic [WIDTH-1:0]       wr_data
);

    rd_state_e        state_q, state_d;
    logic [AW-1:0]    idx_a_q, idx_a_d;
    logic [AW-1:0]    idx_b_q, idx_b_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    logic [AW-1:0]    mux_idx;
    logic [WIDTH-1:0] mux_data;
    logic [WIDTH-1:0] rd_data;

    // The single mux serves A in READ_A and B in READ_B.
    assign mux_idx = (state_q == READ_B) ? idx_b_q : idx_a_q;

    reg_read_mux #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_mux (
        .regs_i (regs_in),
        .idx_i  (mux_idx),
        .data_o (mux_data)
    );

`ifdef REGFILE_READ_BYPASS_EN
    assign rd_data = (write && (writenum == mux_idx)) ? wr_data : mux_data;
`else
    logic unused_bypass;
    assign unused_bypass = ^{write, writenum, wr_data};
    assign rd_data       = mux_data;
`endif

    always_comb begin
        state_d = state_q;
        idx_a_d = idx_a_q;
        idx_b_d = idx_b_q;
        a_d     = a_q;
        b_d     = b_q;
        unique case (state_q)
            IDLE: begin
                if (rd_req) begin
                    idx_a_d = readnum_a;
                    idx_b_d = readnum_b;
                    state_d = READ_A;
                end
            end
            READ_A: begin
                a_d     = rd_data;
                state_d = READ_B;
            end
            READ_B: begin
                b_d     = rd_data;
                state_d = DONE;
            end
            DONE: begin
                if (op_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_a_q <= '0;
            idx_b_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_a_q <= idx_a_d;
            idx_b_q <= idx_b_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign rd_ready = (state_q == IDLE);
    assign op_valid = (state_q == DONE);
    assign a_out    = a_q;
    assign b_out    = b_q;

endmodule

// File: tb/tb_regfile_read_port.sv
module tb_regfile_read_port;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [15:0]  rf [8];
    logic [127:0] regs_in;
    logic         rd_req = 1'b0;
    logic [2:0]   readnum_a = '0;
    logic [2:0]   readnum_b = '0;
    logic         rd_ready;
    logic [15:0]  a_out;
    logic [15:0]  b_out;
    logic         op_valid;
    logic         op_ack = 1'b0;
    logic         write = 1'b0;
    logic [2:0]   writenum = '0;
    logic [15:0]  wr_data = '0;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    assign regs_in = {rf[7], rf[6], rf[5], rf[4], rf[3], rf[2], rf[1], rf[0]};

    regfile_read_port dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .regs_in   (regs_in),
        .rd_req    (rd_req),
        .readnum_a (readnum_a),
        .readnum_b (readnum_b),
        .rd_ready  (rd_ready),
        .a_out     (a_out),
        .b_out     (b_out),
        .op_valid  (op_valid),
        .op_ack    (op_ack),
        .write     (write),
        .writenum  (writenum),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    // Reference model: a transaction accepted at edge t fetches A at edge t+1,
    // B at edge t+2, is valid afterwards and retires on the first ack edge.
    logic        m_busy = 1'b0;
    int unsigned m_n = 0;
    int unsigned m_t = 0;
    logic [2:0]  m_ia = '0, m_ib = '0;
    logic [15:0] m_a = '0, m_b = '0;

    function automatic logic [15:0] fetch(input logic [2:0] idx);
`ifdef REGFILE_READ_BYPASS_EN
        if (write && writenum == idx) return wr_data;
`endif
        return rf[idx];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_a    <= '0;
            m_b    <= '0;
        end else begin
            m_n <= m_n + 1;
            if (!m_busy) begin
                if (rd_req) begin
                    m_busy <= 1'b1;
                    m_t    <= m_n;
                    m_ia   <= readnum_a;
                    m_ib   <= readnum_b;
                end
            end else if (m_n == m_t + 1) begin
                m_a <= fetch(m_ia);
            end else if (m_n == m_t + 2) begin
                m_b <= fetch(m_ib);
            end else if (op_ack) begin
                m_busy <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("rd_ready", {15'd0, rd_ready}, {15'd0, !m_busy});
        chk("op_valid", {15'd0, op_valid}, {15'd0, m_busy && (m_n >= m_t + 3)});
        chk("a_out", a_out, m_a);
        chk("b_out", b_out, m_b);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        foreach (rf[i]) rf[i] = 16'h0;
        rf[2] = 16'h1234;
        rf[5] = 16'hBEEF;
        #1 rst_n = 1'b0;
        rd_req = 1'b1; readnum_a = 3'd2; readnum_b = 3'd5;

        // Reset held with a pending request.
        repeat (3) step();
        chk("rst_a", a_out, 16'h0);
        chk("rst_b", b_out, 16'h0);
        chk("rst_valid", {15'd0, op_valid}, 16'h0);
        chk("rst_ready", {15'd0, rd_ready}, 16'h1);

        // Release: accepted on the next edge (k), basic read.
        rst_n = 1'b1;
        step();
        rd_req = 1'b0; readnum_a = 3'd7; readnum_b = 3'd7;
        chk("acc_ready", {15'd0, rd_ready}, 16'h0);
        step();
        chk("basic_a", a_out, 16'h1234);
        chk("model_a", m_a, 16'h1234);
        step();
        chk("basic_b", b_out, 16'hBEEF);
        chk("model_b", m_b, 16'hBEEF);
        chk("basic_valid", {15'd0, op_valid}, 16'h1);
        op_ack = 1'b1;
        step();
        op_ack = 1'b0;
        chk("basic_ready", {15'd0, rd_ready}, 16'h1);

        // Delayed ack with ignored rd_req pulses.
        rf[1] = 16'h1111; rf[6] = 16'h6666;
        rd_req = 1'b1; readnum_a = 3'd1; readnum_b = 3'd6;
        step();
        rd_req = 1'b0;
        repeat (2) step();
        for (int i = 0; i < 5; i++) begin
            rd_req = i[0]; readnum_a = 3'd0; readnum_b = 3'd0;
            step();
            chk("hold_valid", {15'd0, op_valid}, 16'h1);
            chk("hold_a", a_out, 16'h1111);
            chk("hold_b", b_out, 16'h6666);
        end
        rd_req = 1'b0; op_ack = 1'b1;
        step();
        op_ack = 1'b0;
        chk("hold_ready", {15'd0, rd_ready}, 16'h1);

        // Same index, register changes between READ_A and READ_B.
        rf[7] = 16'h0001;
        rd_req = 1'b1; readnum_a = 3'd7; readnum_b = 3'd7;
        step();
        rd_req = 1'b0;
        step();
        rf[7] = 16'h0002;
        step();
        chk("same_a", a_out, 16'h0001);
        chk("same_b", b_out, 16'h0002);
        op_ack = 1'b1;
        step();
        op_ack = 1'b0;

        // Reset during READ_B.
        rf[0] = 16'hA0A0; rf[4] = 16'h4444;
        rd_req = 1'b1; readnum_a = 3'd0; readnum_b = 3'd4;
        step();
        rd_req = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_a", a_out, 16'h0);
        chk("midrst_valid", {15'd0, op_valid}, 16'h0);
        chk("midrst_ready", {15'd0, rd_ready}, 16'h1);
        repeat (2) step();
        chk("midrst_valid2", {15'd0, op_valid}, 16'h0);
        rst_n = 1'b1;
        step();

        // Same-cycle write during READ_A.
        rf[3] = 16'h00AA;
        rd_req = 1'b1; readnum_a = 3'd3; readnum_b = 3'd3;
        step();
        rd_req = 1'b0;
        write = 1'b1; writenum = 3'd3; wr_data = 16'h5555;
        step();
        write = 1'b0;
`ifdef REGFILE_READ_BYPASS_EN
        chk("bypass_a", a_out, 16'h5555);
`else
        chk("bypass_a", a_out, 16'h00AA);
`endif
        step();
        chk("bypass_b", b_out, 16'h00AA);
        op_ack = 1'b1;
        step();
        op_ack = 1'b0;

        // Randomized traffic, including occasional resets.
        for (int c = 0; c < 600; c++) begin
            rd_req    = ($urandom_range(0, 2) != 0);
            readnum_a = 3'($urandom_range(0, 7));
            readnum_b = 3'($urandom_range(0, 7));
            op_ack    = ($urandom_range(0, 1) != 0);
            write     = ($urandom_range(0, 1) != 0);
            writenum  = 3'($urandom_range(0, 7));
            wr_data   = 16'($urandom);
            if ($urandom_range(0, 1) != 0) rf[$urandom_range(0, 7)] = 16'($urandom);
            rst_n     = ($urandom_range(0, 59) != 0);
            step();
        end
        rst_n = 1'b1; rd_req = 1'b0; op_ack = 1'b1; write = 1'b0;
        repeat (5) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_read_port.md
Name: regfile_read_port

Overview:
- Read side of the 8 x 16-bit register file. The write block updates the registers; this block fetches the two operands (A, B) for the datapath.
- Uses one shared 8:1 read mux, serialised over two cycles: A first, then B.
- Request/ready handshake on the controller side.
- Valid/ack handshake towards the datapath operand latches.

Parameters:
- WIDTH, 16, data width of each register and of each operand output.
- NREGS, 8, number of registers; fixed at 8 in this revision.
- AW, 3, register index width; equals log2(NREGS).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- regs_in  in  NREGS*WIDTH  flattened register file contents; reg0 is in bits [WIDTH-1:0], reg7 is in the top slice.
- rd_req  in  1  read request; sampled only while rd_ready=1.
- readnum_a  in  AW  index of the A operand; captured on accept.
- readnum_b  in  AW  index of the B operand; captured on accept.
- rd_ready  out  1  block idle and able to accept a request.
- a_out  out  WIDTH  registered A operand.
- b_out  out  WIDTH  registered B operand.
- op_valid  out  1  a_out and b_out are both valid.
- op_ack  in  1  consumer has taken the operands.
- write  in  1  register-file write enable; used only by the bypass feature.
- writenum  in  AW  register-file write index; used only by the bypass feature.
- wr_data  in  WIDTH  register-file write data; used only by the bypass feature.

Behaviour:
- States: IDLE, READ_A, READ_B, DONE. State is held in flops; rd_ready and op_valid are decodes of the registered state, so they are glitch-free.
- rd_ready = (state==IDLE). op_valid = (state==DONE).
- Reset (rst_n=0, asynchronous):
  - state=IDLE, a_out=0, b_out=0.
  - Outputs during reset: op_valid=0, rd_ready=1.
  - Reset asserted mid-operation aborts the read immediately and clears a_out/b_out. No partial result is ever flagged valid.
- IDLE:
  - If rd_req=1 at an edge: latch readnum_a and readnum_b into internal idx_a/idx_b, go to READ_A.
  - Otherwise stay in IDLE.
- READ_A: a_out <= regs_in slice idx_a; go to READ_B.
- READ_B: b_out <= regs_in slice idx_b; go to DONE.
- DONE:
  - op_valid=1; a_out and b_out are held stable.
  - If op_ack=1 at an edge: go to IDLE. Otherwise stay in DONE indefinitely.
- Latency:
  - Request accepted at edge k.
  - a_out updates at k+1; b_out updates at k+2.
  - op_valid high from k+2 to the ack edge; the earliest ack edge is k+3.
  - rd_ready high again from k+3 at the earliest.
- Throughput: at most one request per 4 cycles.
- rd_req while rd_ready=0 is ignored and not queued. The requester must hold rd_req until it is accepted.
- op_ack while op_valid=0 is ignored.
- readnum_a/readnum_b changing after accept has no effect; the latched indices are used.
- idx_a==idx_b is legal: both outputs get the same register value. Each is sampled in its own cycle, so the values differ if a write lands in between (see bypass).
- a_out/b_out keep their last values in IDLE; they are not cleared except by reset.
- Index arithmetic: slice select is idx*WIDTH. The index is unsigned and always in range because NREGS=2^AW.

Optional Feature:
- Macro: REGFILE_READ_BYPASS_EN.
- With the macro defined:
  - In READ_A, if write=1 and writenum==idx_a, a_out <= wr_data instead of the regs_in slice.
  - In READ_B, the same rule applies for idx_b / b_out.
  - Effect: a register-file write in the same cycle as the read is forwarded (read-after-write).
- Without the macro:
  - write, writenum and wr_data are unused.
  - The read returns regs_in as it is in that cycle, i.e. the pre-write value.

Decomposition:
- Shared package regfile_pkg:
  - Constants REGFILE_WIDTH=16, REGFILE_NREGS=8, REGFILE_AW=3.
  - Read-port state enum (IDLE, READ_A, READ_B, DONE), 2-bit encoding.
- Sub-module reg_read_mux: combinational NREGS:1 select of a WIDTH slice from regs_in by an AW index. Instantiated once and shared between the A and B phases.
- FSM, index latches, operand registers and bypass compare stay in regfile_read_port.

Test Plan:
- Reset: hold rst_n=0 with rd_req=1 -> a_out=0, b_out=0, op_valid=0, rd_ready=1. Release reset -> request accepted on the next edge.
- Basic read: reg2=16'h1234, reg5=16'hBEEF; rd_req with A=2, B=5 at edge k -> a_out=16'h1234 at k+1, b_out=16'hBEEF at k+2, op_valid=1 at k+2. Ack at k+3 -> rd_ready=1.
- Delayed ack: hold op_ack=0 for 5 cycles -> op_valid stays 1 with outputs stable. rd_req pulses in this window are ignored; no second transaction starts.
- Same index with intervening change: A=B=7, reg7 changes 16'h0001 -> 16'h0002 between the READ_A and READ_B cycles -> a_out=16'h0001, b_out=16'h0002.
- Reset mid-op: assert rst_n=0 in READ_B -> op_valid never asserts, a_out=0, FSM back in IDLE.
- Bypass: reg3=16'h00AA; write=1, writenum=3, wr_data=16'h5555 during READ_A with A=3 -> a_out=16'h5555 with REGFILE_READ_BYPASS_EN defined, 16'h00AA without it.
